// File: rtl/button_conditioner_pkg.sv
// Shared definitions for every button_conditioner instance.
// Holds the FSM state encoding, the default 100 MHz timing constants and
// a helper that sizes the cycle counters.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Defaults for a 100 MHz clk: 10 ms debounce, 500 ms to first repeat,
  // 100 ms between repeats.
  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button signal bundle between the pad, the conditioner and the control FSM.
//   pb            raw, asynchronous, bouncing pad level
//   level         debounced button level
//   pulse         one-cycle press / auto-repeat event
//   release_pulse one-cycle release event ("release" is a reserved word)
//   held          high from the first repeat pulse until release
// master: the conditioner (consumes pb, drives the events)
// slave : the pad/controller side
interface button_conditioner_if;
  logic pb;
  logic level;
  logic pulse;
  logic release_pulse;
  logic held;

  modport master (input pb, output level, output pulse, output release_pulse, output held);
  modport slave  (output pb, input level, input pulse, input release_pulse, input held);
endinterface

// File: rtl/button_conditioner_sync_debounce.sv
// sync_debounce: two-flop synchroniser followed by a debounce counter.
//   clk   system clock
//   rst   asynchronous active-high reset
//   pb    raw pad input
//   level debounced level (registered)
//   rise  combinational: level will go 0->1 at the coming edge
//   fall  combinational: level will go 1->0 at the coming edge
// rise/fall let the parent register its event outputs on the same edge
// that level changes.
module sync_debounce
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   W       = cnt_width(DB_CYCLES);
  localparam logic [W-1:0]  DB_LAST = W'(DB_CYCLES - 1);

  logic         s1;
  logic         s2;
  logic [W-1:0] cnt;
  logic         accept;

  // s2 has disagreed with level for DB_CYCLES consecutive cycles.
  assign accept = (s2 != level) && (cnt == DB_LAST);
  assign rise   = accept && !level;
  assign fall   = accept && level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= pb;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: pad -> debounced level + press / auto-repeat / release
// events for one push button.
//   clk  system clock
//   rst  asynchronous active-high reset (deassertion must be clean)
//   btn  button_conditioner_if.master: pb in; level, pulse,
//        release_pulse, held out (all registered)
//
// state  | meaning
// IDLE   | button released, waiting for an accepted press
// HOLD   | pressed, timing the delay to the first repeat
// REPEAT | auto-repeating every REPEAT_CYCLES, held asserted
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter bit          ENABLE_REPEAT = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  button_conditioner_if.master btn
);

  // REPEAT_CYCLES < HOLD_CYCLES, so one timer sized for HOLD covers both.
  localparam int unsigned   TW        = cnt_width(HOLD_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  logic          level_q;
  logic          rise;
  logic          fall;
  state_t        state;
  logic [TW-1:0] timer;
  logic          pulse_q;
  logic          release_q;
  logic          held_q;

  sync_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_sd (
    .clk   (clk),
    .rst   (rst),
    .pb    (btn.pb),
    .level (level_q),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= HOLD;
            pulse_q <= 1'b1;
            timer   <= '0;
          end
        end
        HOLD: begin
          if (fall) begin
            state     <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            timer     <= '0;
          end else if (timer == HOLD_LAST) begin
            // Without auto-repeat the timer parks here until release.
            if (ENABLE_REPEAT) begin
              state   <= REPEAT;
              pulse_q <= 1'b1;
              held_q  <= 1'b1;
              timer   <= '0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        REPEAT: begin
          // Release wins over a coincident repeat wrap.
          if (fall) begin
            state     <= IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            timer     <= '0;
          end else if (timer == REP_LAST) begin
            pulse_q <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn.level         = level_q;
  assign btn.pulse         = pulse_q;
  assign btn.release_pulse = release_q;
  assign btn.held          = held_q;

endmodule
